// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle RV32M multiply/divide unit in the EX stage.
// Ports: clk, rst (async high), start, func3, rs1, rs2, flush in;
//        stall_req (comb), done (1-cycle pulse), result (registered) out.
module ex_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            stall_req,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [1:0]      r_op;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_div;
    logic [CW-1:0]   r_cnt;
    logic            r_neg_q;
    logic            r_neg_r;

    // Input-side decode, only meaningful while IDLE
    logic            w_sgn;
    logic            w_div0;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;

    assign w_sgn     = ~func3[0];
    assign w_div0    = (rs2 == '0);
    assign w_ovf     = w_sgn && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (&rs2);
    assign w_special = func3[2] & (w_div0 | w_ovf);
    assign w_abs_a   = (w_sgn & rs1[XLEN-1]) ? -rs1 : rs1;
    assign w_abs_b   = (w_sgn & rs2[XLEN-1]) ? -rs2 : rs2;

    // func3[1] selects the remainder; overflow quotient equals rs1
    always_comb begin
        w_special_res = '0;
        if (w_div0)
            w_special_res = func3[1] ? rs1 : '1;
        else if (!func3[1])
            w_special_res = rs1;
    end

    // Multiply: extend each operand to 2*XLEN by its signedness;
    // the low 2*XLEN bits of the product are then exact.
    logic              w_sa;
    logic              w_sb;
    logic [2*XLEN-1:0] w_ea;
    logic [2*XLEN-1:0] w_eb;
    logic [2*XLEN-1:0] w_prod;

    assign w_sa   = (r_op != 2'b11) & r_a[XLEN-1];
    assign w_sb   = (r_op == 2'b01) & r_b[XLEN-1];
    assign w_ea   = {{XLEN{w_sa}}, r_a};
    assign w_eb   = {{XLEN{w_sb}}, r_b};
    assign w_prod = w_ea * w_eb;

    // Restoring division step: shift in next dividend bit, try subtract
    logic [XLEN:0]   w_sh;
    logic [XLEN:0]   w_sub;
    logic            w_ge;
    logic [XLEN-1:0] w_rem_n;
    logic [XLEN-1:0] w_quo_n;

    assign w_sh    = {r_rem, r_quo[XLEN-1]};
    assign w_sub   = w_sh - {1'b0, r_div};
    assign w_ge    = ~w_sub[XLEN];
    assign w_rem_n = w_ge ? w_sub[XLEN-1:0] : w_sh[XLEN-1:0];
    assign w_quo_n = {r_quo[XLEN-2:0], w_ge};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (!func3[2])
                            w_next = S_MUL;
                        else if (w_special)
                            w_next = S_DONE;
                        else
                            w_next = S_DIV;
                    end
                end
                S_MUL:  w_next = S_DONE;
                S_DIV:  if (r_cnt == LAST) w_next = S_DONE;
                S_DONE: w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        done      = (r_state == S_DONE) & ~flush;
        stall_req = start & ~done & ~rst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_div   <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            result  <= '0;
        end else if (!flush) begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op    <= func3[1:0];
                        r_a     <= rs1;
                        r_b     <= rs2;
                        r_cnt   <= '0;
                        r_quo   <= w_abs_a;
                        r_rem   <= '0;
                        r_div   <= w_abs_b;
                        r_neg_q <= w_sgn & (rs1[XLEN-1] ^ rs2[XLEN-1]);
                        r_neg_r <= w_sgn & rs1[XLEN-1];
                        if (w_special)
                            result <= w_special_res;
                    end
                end
                S_MUL: begin
                    result <= (r_op == 2'b00) ? w_prod[XLEN-1:0]
                                              : w_prod[2*XLEN-1:XLEN];
                end
                S_DIV: begin
                    r_quo <= w_quo_n;
                    r_rem <= w_rem_n;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        if (r_op[1])
                            result <= r_neg_r ? -w_rem_n : w_rem_n;
                        else
                            result <= r_neg_q ? -w_quo_n : w_quo_n;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
